// File: rtl/branch_pred_d_pkg.sv
// Shared opcode/rt constants and conditional-branch decode for the D-stage
// branch resolution and prediction unit.
package branch_pred_d_pkg;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;

  typedef enum logic [2:0] {
    BR_NONE, BR_BEQ, BR_BNE, BR_BLEZ, BR_BGTZ, BR_BLTZ, BR_BGEZ
  } br_kind_e;

  function automatic br_kind_e decode_br(input logic [5:0] op, input logic [4:0] rt);
    br_kind_e k;
    k = BR_NONE;
    case (op)
      OP_BEQ:    k = BR_BEQ;
      OP_BNE:    k = BR_BNE;
      OP_BLEZ:   k = BR_BLEZ;
      OP_BGTZ:   k = BR_BGTZ;
      OP_REGIMM: k = (rt == RT_BLTZ) ? BR_BLTZ : (rt == RT_BGEZ) ? BR_BGEZ : BR_NONE;
      default:   k = BR_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/branch_pred_d_bht_table.sv
// Saturating-counter branch history table: one read port for fetch lookup,
// one update port from decode. Reads return the pre-update value (no bypass).
module branch_pred_d_bht_table #(
  parameter int DEPTH    = 64,
  parameter int CTR_BITS = 2,
  localparam int IDX_W   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_pred_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_ONE  = {{(CTR_BITS-1){1'b0}}, 1'b1};

  logic [CTR_BITS-1:0] ctr_q [DEPTH];
  logic [CTR_BITS-1:0] ctr_cur, ctr_d;

  assign rd_pred_o = ctr_q[rd_idx_i][CTR_BITS-1];
  assign ctr_cur   = ctr_q[upd_idx_i];

  always_comb begin
    ctr_d = ctr_cur;
    if (upd_taken_i) begin
      if (ctr_cur != CTR_MAX) ctr_d = ctr_cur + CTR_ONE;
    end else begin
      if (ctr_cur != '0) ctr_d = ctr_cur - CTR_ONE;
    end
  end

  // Reset reinitialises every entry and overrides a coincident update.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_INIT;
    end else if (upd_en_i) begin
      ctr_q[upd_idx_i] <= ctr_d;
    end
  end

endmodule

// File: rtl/branch_pred_d.sv
// D-stage branch resolve + BHT predictor with misprediction flag.
// Optional BRANCH_STAT_EN adds 32-bit branch/mispredict statistics outputs.
module branch_pred_d
  import branch_pred_d_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CTR_BITS  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc_F,
  output logic             pred_F,
  input  logic             en_D,
  input  logic             clr_D,
  input  logic             valid_D,
  input  logic [31:0]      pc_D,
  input  logic [5:0]       OPcode,
  input  logic [4:0]       rt_D,
  input  logic [WIDTH-1:0] RD1,
  input  logic [WIDTH-1:0] RD2,
  output logic             is_branch_D,
  output logic             Branch,
  output logic             mispredict_D,
`ifdef BRANCH_STAT_EN
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_mispred,
`endif
  output logic             pred_D
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [IDX_W-1:0] idx_F, idx_D;
  br_kind_e         kind;
  logic             taken, rd1_neg, rd1_zero, upd;
  logic             pred_q, pred_d;
  logic             unused_pc;

  assign idx_F     = pc_F[IDX_W+1:2];
  assign idx_D     = pc_D[IDX_W+1:2];
  assign unused_pc = ^{pc_F[31:IDX_W+2], pc_F[1:0], pc_D[31:IDX_W+2], pc_D[1:0]};

  assign kind     = decode_br(OPcode, rt_D);
  assign rd1_neg  = RD1[WIDTH-1];
  assign rd1_zero = (RD1 == '0);

  always_comb begin
    taken = 1'b0;
    case (kind)
      BR_BEQ:  taken = (RD1 == RD2);
      BR_BNE:  taken = (RD1 != RD2);
      BR_BLEZ: taken = rd1_neg | rd1_zero;
      BR_BGTZ: taken = ~rd1_neg & ~rd1_zero;
      BR_BLTZ: taken = rd1_neg;
      BR_BGEZ: taken = ~rd1_neg;
      default: taken = 1'b0;
    endcase
  end

  assign is_branch_D  = valid_D & (kind != BR_NONE);
  assign Branch       = valid_D & taken;
  assign mispredict_D = is_branch_D & (Branch != pred_q);
  assign pred_D       = pred_q;
  // Train only when the branch actually leaves D, so a stall counts once.
  assign upd          = is_branch_D & en_D;

  branch_pred_d_bht_table #(
    .DEPTH    (BHT_DEPTH),
    .CTR_BITS (CTR_BITS)
  ) u_bht (
    .clk         (clk),
    .reset       (reset),
    .rd_idx_i    (idx_F),
    .rd_pred_o   (pred_F),
    .upd_en_i    (upd),
    .upd_idx_i   (idx_D),
    .upd_taken_i (Branch)
  );

  always_comb begin
    pred_d = pred_q;
    if (clr_D)     pred_d = 1'b0;
    else if (en_D) pred_d = pred_F;
  end

  always_ff @(posedge clk) begin
    if (reset) pred_q <= 1'b0;
    else       pred_q <= pred_d;
  end

`ifdef BRANCH_STAT_EN
  logic [31:0] stat_br_q, stat_br_d, stat_mp_q, stat_mp_d;

  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (upd) begin
      stat_br_d = stat_br_q + 32'd1;
      if (mispredict_D) stat_mp_d = stat_mp_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches = stat_br_q;
  assign stat_mispred  = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_pred_d.sv
// Directed self-checking bench for branch_pred_d (default parameters).
// Statistics checks are compiled in when BRANCH_STAT_EN is defined.
module tb_branch_pred_d;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_F, pc_D, RD1, RD2;
  logic        pred_F, en_D, clr_D, valid_D;
  logic [5:0]  OPcode;
  logic [4:0]  rt_D;
  logic        is_branch_D, Branch, mispredict_D, pred_D;
`ifdef BRANCH_STAT_EN
  logic [31:0] stat_branches, stat_mispred;
`endif

  int checks = 0;
  int errors = 0;

  branch_pred_d dut (
    .clk(clk), .reset(reset), .pc_F(pc_F), .pred_F(pred_F),
    .en_D(en_D), .clr_D(clr_D), .valid_D(valid_D), .pc_D(pc_D),
    .OPcode(OPcode), .rt_D(rt_D), .RD1(RD1), .RD2(RD2),
    .is_branch_D(is_branch_D), .Branch(Branch), .mispredict_D(mispredict_D),
`ifdef BRANCH_STAT_EN
    .stat_branches(stat_branches), .stat_mispred(stat_mispred),
`endif
    .pred_D(pred_D)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle away from it.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_br(input logic [5:0] op, input logic [4:0] rt,
                        input logic [31:0] a, input logic [31:0] b);
    OPcode = op; rt_D = rt; RD1 = a; RD2 = b; valid_D = 1'b1;
    #1;
  endtask

  initial begin
    reset = 1'b1; pc_F = 32'h3000; pc_D = 32'h3000; en_D = 1'b0; clr_D = 1'b0;
    valid_D = 1'b0; OPcode = 6'd0; rt_D = 5'd0; RD1 = '0; RD2 = '0;
    step(2);
    reset = 1'b0; #1;
    chk("reset_pred_F", 32'(pred_F), 0);
    chk("reset_pred_D", 32'(pred_D), 0);

    // First taken beq: mispredicted, same-index read shows old value
    en_D = 1'b1;
    set_br(6'b000100, 5'd0, 32'd5, 32'd5);
    chk("beq_taken", 32'(Branch), 1);
    chk("beq_isbr", 32'(is_branch_D), 1);
    chk("beq_mispred", 32'(mispredict_D), 1);
    chk("rw_same_old", 32'(pred_F), 0);
    step();
    valid_D = 1'b0; #1;
    chk("rw_same_new", 32'(pred_F), 1);
    chk("pred_D_lag", 32'(pred_D), 0);
    step();
    chk("pred_D_follow", 32'(pred_D), 1);

    // Saturation: counter 10 + 4 taken -> 11; two not-taken -> 10 then 01
    set_br(6'b000100, 5'd0, 32'd7, 32'd7);
    chk("pred_ok_taken", 32'(mispredict_D), 0);
    step(4);
    set_br(6'b000101, 5'd0, 32'd7, 32'd7);
    chk("bne_equal", 32'(Branch), 0);
    chk("bne_isbr", 32'(is_branch_D), 1);
    chk("mispred_nt", 32'(mispredict_D), 1);
    step();
    valid_D = 1'b0; #1;
    chk("sat_then_dec", 32'(pred_F), 1);
    set_br(6'b000101, 5'd0, 32'd7, 32'd7);
    step();
    valid_D = 1'b0; #1;
    chk("sat_dec_twice", 32'(pred_F), 0);

    // Signed compares, no training
    en_D = 1'b0;
    set_br(6'b000001, 5'b00000, 32'h8000_0000, 32'h0); chk("bltz_neg", 32'(Branch), 1);
    set_br(6'b000001, 5'b00001, 32'h8000_0000, 32'h0); chk("bgez_neg", 32'(Branch), 0);
    set_br(6'b000110, 5'd0, 32'h8000_0000, 32'h0);     chk("blez_neg", 32'(Branch), 1);
    set_br(6'b000111, 5'd0, 32'h8000_0000, 32'h0);     chk("bgtz_neg", 32'(Branch), 0);
    set_br(6'b000110, 5'd0, 32'h0, 32'h0);             chk("blez_zero", 32'(Branch), 1);
    set_br(6'b000111, 5'd0, 32'h0, 32'h0);             chk("bgtz_zero", 32'(Branch), 0);
    set_br(6'b000001, 5'b00000, 32'h0, 32'h0);         chk("bltz_zero", 32'(Branch), 0);
    set_br(6'b000001, 5'b00001, 32'h0, 32'h0);         chk("bgez_zero", 32'(Branch), 1);
    set_br(6'b000111, 5'd0, 32'h7fff_ffff, 32'h0);     chk("bgtz_pos", 32'(Branch), 1);
    set_br(6'b000100, 5'd0, 32'd1, 32'd2);             chk("beq_ne", 32'(Branch), 0);
    set_br(6'b000101, 5'd0, 32'd1, 32'd2);             chk("bne_ne", 32'(Branch), 1);
    set_br(6'b000001, 5'b00010, 32'h8000_0000, 32'h0);
    chk("regimm_other_isbr", 32'(is_branch_D), 0);
    chk("regimm_other_br", 32'(Branch), 0);
    set_br(6'b000000, 5'd0, 32'd5, 32'd5);             chk("nonbr_isbr", 32'(is_branch_D), 0);
    set_br(6'b000100, 5'd0, 32'd5, 32'd5);
    valid_D = 1'b0; #1;
    chk("bubble_br", 32'(Branch), 0);
    chk("bubble_isbr", 32'(is_branch_D), 0);

    // Stall at idx 1: three stalled cycles, one release -> single update
    pc_F = 32'h3004; pc_D = 32'h3004;
    set_br(6'b000100, 5'd0, 32'd3, 32'd3);
    step(3);
    chk("stall_no_upd", 32'(pred_F), 0);
    en_D = 1'b1;
    step();
    valid_D = 1'b0; #1;
    chk("stall_release", 32'(pred_F), 1);
    step();
    chk("pred_D_load1", 32'(pred_D), 1);
    en_D = 1'b0; pc_F = 32'h3008;
    step();
    chk("pred_D_hold", 32'(pred_D), 1);
    set_br(6'b000101, 5'd0, 32'd3, 32'd3);
    chk("mispred_predD1", 32'(mispredict_D), 1);
    set_br(6'b000101, 5'd0, 32'd3, 32'd4);
    chk("correct_predD1", 32'(mispredict_D), 0);
    valid_D = 1'b0;
    pc_F = 32'h3004; clr_D = 1'b1; en_D = 1'b1;
    step();
    chk("clr_wins", 32'(pred_D), 0);
    clr_D = 1'b0; en_D = 1'b1;
    set_br(6'b000101, 5'd0, 32'd3, 32'd3);
    step();
    valid_D = 1'b0; #1;
    chk("stall_single_upd", 32'(pred_F), 0);

    // Mid-run reset overrides pending update and reinitialises the table
    pc_F = 32'h300C; pc_D = 32'h300C;
    set_br(6'b000100, 5'd0, 32'd9, 32'd9);
    step();
    chk("idx3_trained", 32'(pred_F), 1);
    reset = 1'b1;
    step();
    reset = 1'b0; valid_D = 1'b0; #1;
    chk("rst_table", 32'(pred_F), 0);
    chk("rst_pred_D", 32'(pred_D), 0);
    pc_F = 32'h3000; #1;
    chk("rst_table_idx0", 32'(pred_F), 0);

`ifdef BRANCH_STAT_EN
    chk("stat_br_rst", stat_branches, 0);
    chk("stat_mp_rst", stat_mispred, 0);
    // pc_F on an untouched index keeps pred_D at 0, so mispredicts == taken
    pc_F = 32'h3020; pc_D = 32'h3010; en_D = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 2 || i == 5 || i == 8) set_br(6'b000100, 5'd0, 32'd1, 32'd1);
      else                            set_br(6'b000100, 5'd0, 32'd1, 32'd2);
      step();
      valid_D = 1'b0; #1;
      step();
    end
    chk("stat_branches", stat_branches, 10);
    chk("stat_mispred", stat_mispred, 3);
    reset = 1'b1;
    step();
    reset = 1'b0; #1;
    chk("stat_br_clear", stat_branches, 0);
    chk("stat_mp_clear", stat_mispred, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
